// File: rtl/retire_unit_pkg.sv
// Shared types for the retire stage: ROB retire packet, retire FSM states and
// free-list return packet.
package retire_unit_pkg;

  localparam int unsigned SUPERSCALAR_WAYS = 2;
  localparam int unsigned N_PHYS_REG_BITS  = 6;
  localparam int unsigned XLEN             = 32;
  localparam int unsigned N_ARCH_REGS      = 32;

  typedef struct packed {
    logic                       complete;
    logic                       precise_state_enable;
    logic                       halt;
    logic [4:0]                 ar_idx;
    logic [N_PHYS_REG_BITS-1:0] t_idx;
    logic [N_PHYS_REG_BITS-1:0] told_idx;
    logic [XLEN-1:0]            target_pc;
    logic [XLEN-1:0]            value;
    logic [XLEN-1:0]            npc;
  } ROB_PACKET;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } RETIRE_STATE;

  typedef struct packed {
    logic                       valid;
    logic [N_PHYS_REG_BITS-1:0] idx;
  } RETIRE_FREELIST_PACKET;

endpackage

// File: rtl/arch_map_table.sv
// Committed architectural map: identity on reset, WAYS write ports where the
// highest-numbered enabled port wins on an address collision.
module arch_map_table
  import retire_unit_pkg::*;
#(
  parameter int unsigned WAYS    = SUPERSCALAR_WAYS,
  parameter int unsigned N_ARCH  = N_ARCH_REGS,
  parameter int unsigned PR_BITS = N_PHYS_REG_BITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WAYS-1:0]    we_i,
  input  logic [4:0]         waddr_i [WAYS],
  input  logic [PR_BITS-1:0] wdata_i [WAYS],
  output logic [PR_BITS-1:0] map_o   [N_ARCH]
);

  logic [PR_BITS-1:0] map_q [N_ARCH];

  // Ports are visited in ascending order so the last (youngest) write lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned r = 0; r < N_ARCH; r++) begin
        map_q[r] <= PR_BITS'(r);
      end
    end else begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (we_i[w]) begin
          map_q[waddr_i[w]] <= wdata_i[w];
        end
      end
    end
  end

  assign map_o = map_q;

endmodule

// File: rtl/retire_unit.sv
// Retire stage: accepts an in-order group of completed ROB entries, commits
// them to the map table, returns old tags, and raises squash / halt.
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int unsigned WAYS    = SUPERSCALAR_WAYS,
  parameter int unsigned N_ARCH  = 32,
  parameter int unsigned PR_BITS = N_PHYS_REG_BITS
) (
  input  logic                         clock,
  input  logic                         reset,
  input  ROB_PACKET                    rob_retire_in [WAYS],
  output logic [WAYS-1:0]              free_valid,
  output logic [PR_BITS-1:0]           free_idx     [WAYS],
  output logic [PR_BITS-1:0]           arch_map     [N_ARCH],
  output logic                         squash,
  output logic [XLEN-1:0]              squash_pc,
  output logic                         halted,
  output logic [WAYS-1:0]              commit_valid,
  output logic [4:0]                   commit_ar    [WAYS],
  output logic [XLEN-1:0]              commit_value [WAYS],
  output logic [XLEN-1:0]              commit_npc   [WAYS],
  output logic [$clog2(WAYS+1)-1:0]    retire_cnt
);

  localparam int unsigned CW = $clog2(WAYS + 1);

  RETIRE_STATE           state_q, state_d;
  logic [XLEN-1:0]       squash_pc_q, squash_pc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WAYS-1:0]       acc, map_we;
  logic                  go;

  RETIRE_FREELIST_PACKET free_q       [WAYS];
  logic [WAYS-1:0]       commit_v_q;
  logic [4:0]            commit_ar_q  [WAYS];
  logic [XLEN-1:0]       commit_val_q [WAYS];
  logic [XLEN-1:0]       commit_npc_q [WAYS];

  logic [4:0]            map_waddr    [WAYS];
  logic [PR_BITS-1:0]    map_wdata    [WAYS];

  // A running "group still open" flag avoids a self-referencing acc chain.
  always_comb begin
    acc         = '0;
    map_we      = '0;
    state_d     = state_q;
    squash_pc_d = squash_pc_q;
    cnt_d       = '0;
    go          = (state_q == RUN);
    for (int unsigned w = 0; w < WAYS; w++) begin
      acc[w]    = go & rob_retire_in[w].complete;
      go        = acc[w] & ~rob_retire_in[w].precise_state_enable & ~rob_retire_in[w].halt;
      map_we[w] = acc[w] & (rob_retire_in[w].ar_idx != 5'd0);
      map_waddr[w] = rob_retire_in[w].ar_idx;
      map_wdata[w] = PR_BITS'(rob_retire_in[w].t_idx);
      if (acc[w]) begin
        cnt_d = cnt_d + CW'(1);
        if (rob_retire_in[w].halt) begin
          state_d = HALTED;
        end else if (rob_retire_in[w].precise_state_enable) begin
          state_d     = SQUASH;
          squash_pc_d = rob_retire_in[w].target_pc;
        end
      end
    end
    case (state_q)
      SQUASH:  state_d = RUN;
      HALTED:  state_d = HALTED;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= RUN;
      squash_pc_q <= '0;
      cnt_q       <= '0;
      commit_v_q  <= '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
        free_q[w]       <= '0;
        commit_ar_q[w]  <= '0;
        commit_val_q[w] <= '0;
        commit_npc_q[w] <= '0;
      end
    end else begin
      state_q     <= state_d;
      squash_pc_q <= squash_pc_d;
      cnt_q       <= cnt_d;
      commit_v_q  <= acc;
      for (int unsigned w = 0; w < WAYS; w++) begin
        free_q[w].valid <= map_we[w];
        free_q[w].idx   <= map_we[w] ? rob_retire_in[w].told_idx : '0;
        commit_ar_q[w]  <= acc[w] ? rob_retire_in[w].ar_idx : '0;
        commit_val_q[w] <= acc[w] ? rob_retire_in[w].value  : '0;
        commit_npc_q[w] <= acc[w] ? rob_retire_in[w].npc    : '0;
      end
    end
  end

  arch_map_table #(
    .WAYS    (WAYS),
    .N_ARCH  (N_ARCH),
    .PR_BITS (PR_BITS)
  ) u_map (
    .clock   (clock),
    .reset   (reset),
    .we_i    (map_we),
    .waddr_i (map_waddr),
    .wdata_i (map_wdata),
    .map_o   (arch_map)
  );

  always_comb begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      free_valid[w] = free_q[w].valid;
      free_idx[w]   = PR_BITS'(free_q[w].idx);
    end
  end

  assign squash       = (state_q == SQUASH);
  assign halted       = (state_q == HALTED);
  assign squash_pc    = squash_pc_q;
  assign retire_cnt   = cnt_q;
  assign commit_valid = commit_v_q;
  assign commit_ar    = commit_ar_q;
  assign commit_value = commit_val_q;
  assign commit_npc   = commit_npc_q;

endmodule

// File: tb/tb_retire_unit.sv
// Scoreboard bench for retire_unit: stimulus queues the expected registered
// response per cycle, a monitor pops and compares one cycle later.
module tb_retire_unit;
  import retire_unit_pkg::*;

  localparam int W = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  ROB_PACKET       pkt [W];
  logic [W-1:0]    free_valid;
  logic [5:0]      free_idx [W];
  logic [5:0]      arch_map [32];
  logic            squash;
  logic [31:0]     squash_pc;
  logic            halted;
  logic [W-1:0]    commit_valid;
  logic [4:0]      commit_ar [W];
  logic [31:0]     commit_value [W];
  logic [31:0]     commit_npc [W];
  logic [1:0]      retire_cnt;

  retire_unit #(.WAYS(W), .N_ARCH(32), .PR_BITS(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .rob_retire_in (pkt),
    .free_valid    (free_valid),
    .free_idx      (free_idx),
    .arch_map      (arch_map),
    .squash        (squash),
    .squash_pc     (squash_pc),
    .halted        (halted),
    .commit_valid  (commit_valid),
    .commit_ar     (commit_ar),
    .commit_value  (commit_value),
    .commit_npc    (commit_npc),
    .retire_cnt    (retire_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    int fv, fi0, fi1, cv, car0, cval0, cnt, sq, spc, cs, hl, ma, mav, mb, mbv;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(string nm, longint unsigned act, longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic ROB_PACKET mk(bit c, int ar, int t, int told,
                                   bit pse = 1'b0, bit h = 1'b0, int tpc = 0);
    ROB_PACKET p;
    p                      = '0;
    p.complete             = c;
    p.ar_idx               = 5'(ar);
    p.t_idx                = 6'(t);
    p.told_idx             = 6'(told);
    p.precise_state_enable = pse;
    p.halt                 = h;
    p.target_pc            = 32'(tpc);
    p.value                = 32'h1000 + 32'(t);
    p.npc                  = 32'h4000 + 32'(ar);
    return p;
  endfunction

  function automatic exp_t ex(int fv, int fi0, int fi1, int cv, int car0, int cval0,
                              int cnt, int sq, int spc, int cs, int hl,
                              int ma, int mav, int mb, int mbv);
    exp_t r;
    r.fv = fv; r.fi0 = fi0; r.fi1 = fi1; r.cv = cv; r.car0 = car0; r.cval0 = cval0;
    r.cnt = cnt; r.sq = sq; r.spc = spc; r.cs = cs; r.hl = hl;
    r.ma = ma; r.mav = mav; r.mb = mb; r.mbv = mbv;
    return r;
  endfunction

  task automatic step(bit rst, ROB_PACKET p0, ROB_PACKET p1, exp_t x);
    @(negedge clock);
    reset  = rst;
    pkt[0] = p0;
    pkt[1] = p1;
    q.push_back(x);
    @(posedge clock);
  endtask

  always @(posedge clock) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("free_valid",   free_valid,   e.fv);
      chk("retire_cnt",   retire_cnt,   e.cnt);
      chk("commit_valid", commit_valid, e.cv);
      chk("squash",       squash,       e.sq);
      chk("halted",       halted,       e.hl);
      if ((e.fv & 1) != 0) chk("free_idx0", free_idx[0], e.fi0);
      if ((e.fv & 2) != 0) chk("free_idx1", free_idx[1], e.fi1);
      if ((e.cv & 1) != 0) begin
        chk("commit_ar0",    commit_ar[0],    e.car0);
        chk("commit_value0", commit_value[0], e.cval0);
        chk("commit_npc0",   commit_npc[0],   32'h4000 + 32'(e.car0));
      end
      if (e.cs != 0) chk("squash_pc", squash_pc, e.spc);
      chk("map_a", arch_map[e.ma], e.mav);
      chk("map_b", arch_map[e.mb], e.mbv);
    end
  end

  initial begin
    ROB_PACKET idle;
    idle   = mk(1'b0, 0, 0, 0);
    pkt[0] = idle;
    pkt[1] = idle;
    // reset state: identity map, everything else clear
    step(1, idle, idle, ex(0,0,0,0,0,0,0,0,0,1,0, 5,5, 6,6));
    step(1, idle, idle, ex(0,0,0,0,0,0,0,0,0,1,0, 5,5, 6,6));
    // two-way retire
    step(0, mk(1,5,40,5), mk(1,6,41,6), ex(3,5,6,3,5,'h1028,2,0,0,1,0, 5,40, 6,41));
    // same ar in both ways: way1 wins map, both free
    step(0, mk(1,3,33,3), mk(1,3,34,33), ex(3,3,33,3,3,'h1021,2,0,0,1,0, 3,34, 5,40));
    step(0, idle, idle, ex(0,0,0,0,0,0,0,0,0,1,0, 3,34, 6,41));
    // ar=0: commit but no free, no map write
    step(0, mk(1,0,50,0), idle, ex(0,0,0,1,0,'h1032,1,0,0,1,0, 0,0, 3,34));
    // hole at way0 blocks way1
    step(0, idle, mk(1,7,45,7), ex(0,0,0,0,0,0,0,0,0,1,0, 7,7, 6,41));
    // mispredict on way0 drops way1
    step(0, mk(1,8,46,8,1,0,'h100), mk(1,9,47,9), ex(1,8,0,1,8,'h102e,1,1,'h100,1,0, 8,46, 9,9));
    // input during SQUASH ignored
    step(0, mk(1,10,48,10), mk(1,11,52,11), ex(0,0,0,0,0,0,0,0,'h100,1,0, 10,10, 11,11));
    step(0, mk(1,10,48,10), idle, ex(1,10,0,1,10,'h1030,1,0,'h100,1,0, 10,48, 8,46));
    // halt on way0
    step(0, mk(1,12,49,12,0,1), mk(1,13,53,13), ex(1,12,0,1,12,'h1031,1,0,'h100,1,1, 12,49, 13,13));
    step(0, mk(1,14,54,14), mk(1,15,55,15), ex(0,0,0,0,0,0,0,0,'h100,1,1, 14,14, 12,49));
    step(1, idle, idle, ex(0,0,0,0,0,0,0,0,0,1,0, 12,12, 5,5));
    // halt and mispredict on same way: halt wins
    step(0, mk(1,1,20,1,1,1,'h200), idle, ex(1,1,0,1,1,'h1014,1,0,0,0,1, 1,20, 3,3));
    step(0, idle, idle, ex(0,0,0,0,0,0,0,0,0,0,1, 1,20, 0,0));
    step(1, idle, idle, ex(0,0,0,0,0,0,0,0,0,1,0, 1,1, 0,0));
    // reset during SQUASH
    step(0, mk(1,2,21,2,1,0,'h300), mk(1,4,22,4), ex(1,2,0,1,2,'h1015,1,1,'h300,1,0, 2,21, 4,4));
    step(1, mk(1,4,22,4), idle, ex(0,0,0,0,0,0,0,0,0,1,0, 2,2, 4,4));
    step(0, mk(1,4,22,4), idle, ex(1,4,0,1,4,'h1016,1,0,0,1,0, 4,22, 2,2));
    @(negedge clock);
    pkt[0] = idle;
    pkt[1] = idle;
    repeat (2) @(posedge clock);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/retire_unit.md
# retire_unit

Retire-side consumer of the re-order buffer's retire packets. Each cycle it takes up to `SUPERSCALAR_WAYS` in-order retiring entries and updates the architectural map table. It returns each retired entry's `told_idx` to the free list and emits a commit trace. On a retired mispredict or halt it raises the one-cycle squash or the sticky halt. It sits between the ROB and the map table, free list and front-end PC logic.

## Interface
- `WAYS`, default `` `SUPERSCALAR_WAYS ``: retire width.
- `N_ARCH`, default 32: architectural registers.
- `PR_BITS`, default `` `N_PHYS_REG_BITS ``: physical tag width.
- `clock` in, 1: clock.
- `reset` in, 1: reset, synchronous, active-high.
- `rob_retire_in` in, `ROB_PACKET [WAYS]`: retiring entries. A way is valid iff `.complete`. Ways are in program order.
- `free_valid` out, `[WAYS]`: a tag is returned on that way.
- `free_idx` out, `[WAYS][PR_BITS]`: returned `told_idx` values.
- `arch_map` out, `[N_ARCH][PR_BITS]`: committed map, registered.
- `squash` out, 1: flush the whole pipeline, one-cycle pulse.
- `squash_pc` out, `` `XLEN ``: redirect target, valid with `squash`.
- `halted` out, 1: sticky halt indication.
- `commit_valid` out, `[WAYS]`: trace of committed instructions.
- `commit_ar` out, `[WAYS][5]`: trace destination register.
- `commit_value` out, `[WAYS][` `` `XLEN `` `]`: trace destination value.
- `commit_npc` out, `[WAYS][` `` `XLEN `` `]`: trace NPC.
- `retire_cnt` out, `$clog2(WAYS+1)`: number of ways accepted this cycle.

## Operation
- FSM states:
  - RUN: accepts retires.
  - SQUASH: the single cycle in which `squash`=1. All input ways are ignored.
  - HALTED: terminal until reset. Inputs are ignored.
- Acceptance mask, combinational, in RUN only:
  - `acc[0]` = `complete[0]`.
  - `acc[i]` = `acc[i-1]` & `complete[i]` & ~`precise_state_enable[i-1]` & ~`halt[i-1]`.
  - A hole in the inputs terminates the group.
- Per accepted way i:
  - If `ar_idx`≠0: `arch_map[ar_idx]` ← `t_idx`, and `free_valid[i]`=1 with `free_idx[i]`=`told_idx`.
  - If `ar_idx`=0: no map write and no free.
  - The commit trace is asserted for every accepted way, including `ar_idx`=0.
- Same `ar_idx` in several accepted ways: the highest way wins the map write. Every way still frees its own `told_idx`.
- An accepted way with `precise_state_enable`: latch `target_pc` into `squash_pc`, next state SQUASH.
- An accepted way with `halt`: next state HALTED.
- If one way has both `halt` and `precise_state_enable`, halt wins.
- SQUASH → RUN unconditionally after one cycle.
- Reset values:
  - `arch_map[r]` = r.
  - State RUN.
  - All other outputs 0.

## Timing
- All outputs are registered: free, commit, `retire_cnt` and the map update appear at the clock edge after the cycle the packet is presented (1-cycle latency).
- `squash` goes high the cycle after the triggering retire, for exactly 1 cycle.
- `halted` goes high the cycle after the halt retire and stays high until reset.
- Free-list returns and the commit trace of the triggering instruction appear in the same cycle as `squash`/`halted` rise. Younger ways in that group are dropped.
- Reset asserted mid-SQUASH or mid-HALTED: the next cycle is RUN with the identity map and `squash`=0.
- Free and commit outputs are single-cycle pulses with no handshake; consumers must accept every cycle.

## Structure
- Shared package:
  - `ROB_PACKET`.
  - `RETIRE_STATE` enum {RUN, SQUASH, HALTED}.
  - A new `RETIRE_FREELIST_PACKET` {valid, idx}.
  - `` `N_ARCH_REGS ``.
- Sub-module `arch_map_table`: the N_ARCH×PR_BITS register file with WAYS priority-ordered write ports and identity reset.
- The FSM and acceptance mask live in the top module.

## Test plan
- Two-way retire, way0 ar=5 t=40 told=5, way1 ar=6 t=41 told=6:
  - Next cycle `arch_map[5]`=40, `arch_map[6]`=41.
  - `free_idx`={5,6}, both valid.
  - `retire_cnt`=2.
- Same ar: way0 ar=3 t=33 told=3, way1 ar=3 t=34 told=33:
  - `arch_map[3]`=34.
  - Frees {3,33}.
- Mispredict: way0 `precise_state_enable`=1, `target_pc`=0x100, way1 complete:
  - Only way0 is committed and `retire_cnt`=1.
  - `squash`=1 for one cycle with `squash_pc`=0x100.
  - Input presented during SQUASH is ignored.
- Halt: way0 halt=1:
  - `halted`=1 from the next cycle onward.
  - Later complete packets cause no map change and no frees.
  - Reset restores the identity map and `halted`=0.
- ar=0: way0 ar=0 t=50 told=0:
  - `commit_valid[0]`=1, `free_valid[0]`=0.
  - `arch_map` unchanged.
- Hole: way0 incomplete, way1 complete:
  - Nothing is accepted and `retire_cnt`=0.
